// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the CSR file and the performance counters.
package core_config_pkg;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned NUM_PERF_CTR = 5;
   localparam int unsigned PERF_CTR_W   = 64;

   typedef enum logic [2:0] {
      PC_CYCLE = 3'd0,
      PC_INSTR = 3'd1,
      PC_FLUSH = 3'd2,
      PC_WAIT  = 3'd3,
      PC_DECOD = 3'd4
   } perf_idx_t;

endpackage

// File: rtl/perf_ctr_slice.sv
// One performance counter: clear > half-word preload > increment, with a
// snapshot shadow driving the outputs and a registered wrap pulse.
module perf_ctr_slice #(
   parameter int unsigned W = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           wr_en,
   input  logic           wr_hi,
   input  logic [W/2-1:0] wr_data,
   input  logic           inc,
   input  logic           inhibit,
   input  logic           snap_en,
   output logic [W-1:0]   value,
   output logic           ovf
);

   logic [W-1:0] cnt;
   logic [W-1:0] cnt_nxt;
   logic         wrap;

   always_comb begin
      cnt_nxt = cnt;
      wrap    = 1'b0;
      if (clr) begin
         cnt_nxt = '0;
      end else if (wr_en) begin
         if (wr_hi) cnt_nxt[W-1:W/2] = wr_data;
         else       cnt_nxt[W/2-1:0] = wr_data;
      end else if (inc && !inhibit) begin
         // full-width add so the carry into the high half lands on the same edge
         cnt_nxt = cnt + W'(1);
         wrap    = &cnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         value <= '0;
         ovf   <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         ovf <= wrap;
         if (!snap_en) value <= cnt_nxt;
      end
   end

endmodule

// File: rtl/perf_counter_unit.sv
// Hardware performance counters for the CSR file: event input stage, preload
// decode and L/H port mapping around one slice per counter.
module perf_counter_unit #(
   parameter int unsigned XLEN = core_config_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ev_instr,
   input  logic            ev_flush,
   input  logic            ev_wait,
   input  logic            ev_decod,
   input  logic [4:0]      inhibit,
   input  logic [4:0]      clr,
   input  logic            wr_en,
   input  logic [2:0]      wr_sel,
   input  logic            wr_hi,
   input  logic [XLEN-1:0] wr_data,
   input  logic            snap_en,
   output logic [XLEN-1:0] cycleL,
   output logic [XLEN-1:0] cycleH,
   output logic [XLEN-1:0] instructionsL,
   output logic [XLEN-1:0] instructionsH,
   output logic [XLEN-1:0] flushsL,
   output logic [XLEN-1:0] flushsH,
   output logic [XLEN-1:0] waitsL,
   output logic [XLEN-1:0] waitsH,
   output logic [XLEN-1:0] decodedL,
   output logic [XLEN-1:0] decodedH,
   output logic [4:0]      ovf
);

   import core_config_pkg::*;

   localparam int unsigned CTR_W = 2 * XLEN;

   logic [NUM_PERF_CTR-1:1] ev_q;
   logic [NUM_PERF_CTR-1:0] inc;
   logic [CTR_W-1:0]        ctr_val [NUM_PERF_CTR];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ev_q <= '0;
      else        ev_q <= {ev_decod, ev_wait, ev_flush, ev_instr};
   end

   // the cycle counter has no input stage and counts every edge
   assign inc = {ev_q, 1'b1};

   for (genvar g = 0; g < NUM_PERF_CTR; g++) begin : g_ctr
      perf_ctr_slice #(
         .W (CTR_W)
      ) u_slice (
         .clk     (clk),
         .rst_n   (rst_n),
         .clr     (clr[g]),
         .wr_en   (wr_en && (wr_sel == 3'(g))),
         .wr_hi   (wr_hi),
         .wr_data (wr_data),
         .inc     (inc[g]),
         .inhibit (inhibit[g]),
         .snap_en (snap_en),
         .value   (ctr_val[g]),
         .ovf     (ovf[g])
      );
   end

   assign cycleL        = ctr_val[PC_CYCLE][XLEN-1:0];
   assign cycleH        = ctr_val[PC_CYCLE][CTR_W-1:XLEN];
   assign instructionsL = ctr_val[PC_INSTR][XLEN-1:0];
   assign instructionsH = ctr_val[PC_INSTR][CTR_W-1:XLEN];
   assign flushsL       = ctr_val[PC_FLUSH][XLEN-1:0];
   assign flushsH       = ctr_val[PC_FLUSH][CTR_W-1:XLEN];
   assign waitsL        = ctr_val[PC_WAIT][XLEN-1:0];
   assign waitsH        = ctr_val[PC_WAIT][CTR_W-1:XLEN];
   assign decodedL      = ctr_val[PC_DECOD][XLEN-1:0];
   assign decodedH      = ctr_val[PC_DECOD][CTR_W-1:XLEN];

endmodule
